// File: rtl/pc_next_ctrl.sv
// rtl/pc_next_ctrl.sv - next-PC sequencer with redirect flushes and status
//
// Owns the fetch PC and picks the next PC from three sources, highest first:
// an EX-stage redirect (JR or taken branch), an ID-stage J/JAL jump, or
// sequential PC+4. A stall holds the PC unless an EX redirect overrides it.
//
// Ports:
//   clk_i         rising-edge clock
//   rst_i         asynchronous active-low reset
//   stall_i       hazard-unit stall, holds PC and the ID-stage PC copy
//   jump_i        J/JAL decoded in ID
//   jidx_i        instr[25:0] of the ID-stage instruction
//   branch_i      branch resolved taken in EX
//   btarget_i     EX branch target
//   jr_i          JR in EX
//   jraddr_i      JR register value
//   pc_o          current fetch PC (registered)
//   pc_plus4_o    pc_o + 4
//   flush_ifid_o  clear IF/ID on this edge
//   flush_idex_o  clear ID/EX on this edge
//   misalign_o    sticky: JR target with addr[1:0] != 0 seen
//   redir_cnt_o   saturating count of taken redirects

module pc_next_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             stall_i,
    input  logic             jump_i,
    input  logic [25:0]      jidx_i,
    input  logic             branch_i,
    input  logic [31:0]      btarget_i,
    input  logic             jr_i,
    input  logic [31:0]      jraddr_i,
    output logic [31:0]      pc_o,
    output logic [31:0]      pc_plus4_o,
    output logic             flush_ifid_o,
    output logic             flush_idex_o,
    output logic             misalign_o,
    output logic [CNT_W-1:0] redir_cnt_o
);

    typedef enum logic {
        ST_RUN = 1'b0,
        ST_RDR = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    // Only bits [31:2] of the ID-stage PC feed the jump target, so the
    // low two bits are not kept.
    logic [31:2]      pc_id_q, pc_id_d;
    logic             misalign_q, misalign_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             ex_redir;
    logic             id_jump;
    logic [3:0]       jt_hi;
    logic [31:0]      jt;

    assign ex_redir = jr_i | branch_i;

    // A jump in the cycle after a redirect sits in a flushed ID slot.
    assign id_jump = jump_i & ~stall_i & ~ex_redir & (state_q == ST_RUN);

    // Upper nibble of (pc_id + 4): a carry reaches bit 28 only when
    // bits [27:2] are all ones.
    assign jt_hi = pc_id_q[31:28] + {3'b000, &pc_id_q[27:2]};
    assign jt    = {jt_hi, jidx_i, 2'b00};

    always_comb begin
        pc_d       = pc_q + 32'd4;
        pc_id_d    = pc_id_q;
        misalign_d = misalign_q;
        cnt_d      = cnt_q;
        state_d    = ST_RUN;

        if (ex_redir) begin
            pc_d    = jr_i ? (jraddr_i & ~32'h3) : btarget_i;
            state_d = ST_RDR;
        end else if (id_jump) begin
            pc_d    = jt;
            state_d = ST_RDR;
        end else if (stall_i) begin
            pc_d    = pc_q;
        end

        if (!stall_i || ex_redir) begin
            pc_id_d = pc_q[31:2];
        end

        if (jr_i && (jraddr_i[1:0] != 2'b00)) begin
            misalign_d = 1'b1;
        end

        if ((ex_redir || id_jump) && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= ST_RUN;
            pc_q       <= RESET_PC;
            pc_id_q    <= RESET_PC[31:2];
            misalign_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pc_id_q    <= pc_id_d;
            misalign_q <= misalign_d;
            cnt_q      <= cnt_d;
        end
    end

    assign pc_o         = pc_q;
    assign pc_plus4_o   = pc_q + 32'd4;
    // Flushes are combinational but must stay low while reset is held.
    assign flush_ifid_o = rst_i & (ex_redir | id_jump);
    assign flush_idex_o = rst_i & ex_redir;
    assign misalign_o   = misalign_q;
    assign redir_cnt_o  = cnt_q;

endmodule
